// File: rtl/game_tick_scheduler.sv
// Snake game flow FSM (idle/run/pause/over) with a level-scaled tick divider and step req/ack.
// Optional SCHED_FAST_SIM_EN shortens every period by 10_000x (floor, minimum 4) for simulation.
module game_tick_scheduler #(
    parameter int CLK_FREQ         = 50_000_000,
    parameter int BASE_TPS         = 4,
    parameter int TPS_STEP         = 2,
    parameter int MAX_LEVEL        = 7,
    parameter int APPLES_PER_LEVEL = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause_btn,
    input  logic       apple_eaten,
    input  logic       collision,
    input  logic       step_ack,
    output logic       step_req,
    output logic       game_tick,
    output logic [1:0] state,
    output logic [2:0] level,
    output logic [7:0] overrun_cnt
);

    function automatic int calc_period(input int lvl);
        int p;
        p = CLK_FREQ / (BASE_TPS + lvl * TPS_STEP);
`ifdef SCHED_FAST_SIM_EN
        p = p / 10_000;
        if (p < 4) p = 4;
`endif
        if (p < 1) p = 1;
        return p;
    endfunction

    localparam int P0 = calc_period(0);
    localparam int CW = (P0 > 2) ? $clog2(P0) : 1;
    localparam int AW = $clog2(APPLES_PER_LEVEL + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_e;

    // Reload values are elaboration-time constants; no divider is built.
    logic [CW-1:0] reload_tbl [MAX_LEVEL+1];
    for (genvar g = 0; g <= MAX_LEVEL; g++) begin : g_tbl
        assign reload_tbl[g] = CW'(calc_period(g) - 1);
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    level_q, level_d;
    logic [AW-1:0] apples_q, apples_d;
    logic [7:0]    ovr_q, ovr_d;
    logic          req_q, req_d;
    logic          tick_q, tick_d;
    logic          pend_q, pend_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        apples_d = apples_q;
        ovr_d    = ovr_q;
        req_d    = req_q;
        tick_d   = 1'b0;
        pend_d   = 1'b0;
        unique case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = reload_tbl[0];
                    level_d  = 3'd0;
                    apples_d = '0;
                    ovr_d    = 8'd0;
                    req_d    = 1'b0;
                end
            end
            RUN, PAUSE: begin
                if (collision) begin
                    state_d = OVER;
                    req_d   = 1'b0;
                end else begin
                    if (req_q && step_ack) req_d = 1'b0;
                    // Tick deferred by an ack that landed on the due cycle.
                    if (pend_q) begin
                        tick_d = 1'b1;
                        req_d  = 1'b1;
                    end
                    if (state_q == RUN) begin
                        if (pause_btn) begin
                            state_d = PAUSE;
                        end else if (apple_eaten) begin
                            if (apples_q == AW'(APPLES_PER_LEVEL - 1)) begin
                                apples_d = '0;
                                if (level_q != 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
                            end else begin
                                apples_d = apples_q + 1'b1;
                            end
                        end
                        if (cnt_q == '0) begin
                            cnt_d = reload_tbl[level_q];
                            if (!req_q) begin
                                tick_d = 1'b1;
                                req_d  = 1'b1;
                            end else if (step_ack) begin
                                pend_d = 1'b1;
                            end else if (ovr_q != 8'hFF) begin
                                ovr_d = ovr_q + 8'd1;
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end else if (pause_btn) begin
                        state_d = RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            level_q  <= 3'd0;
            apples_q <= '0;
            ovr_q    <= 8'd0;
            req_q    <= 1'b0;
            tick_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            apples_q <= apples_d;
            ovr_q    <= ovr_d;
            req_q    <= req_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
        end
    end

    assign step_req    = req_q;
    assign game_tick   = tick_q;
    assign state       = state_q;
    assign level       = level_q;
    assign overrun_cnt = ovr_q;

endmodule
